// File: rtl/gate_vector_sequencer.sv
// gate_vector_sequencer
// Clocked stimulus source and response checker for a 3-input combinational
// gate. Sweeps {a,b,c} through 000..111 and holds each vector HOLD_CYCLES
// cycles. Samples f_in in the last cycle of each hold and compares it with
// the truth table of the latched gate function. Reports a fail map, an error
// count and pass/done status.
module gate_vector_sequencer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] func,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       f_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [7:0] fail_vec
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Last hold-counter value of a vector; the gate output is judged there.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    // Expected gate output for function fn applied to vector v = {a,b,c}.
    function automatic logic gate_ref(input logic [2:0] fn, input logic [2:0] v);
        logic r;
        case (fn)
            3'd0:    r = &v;
            3'd1:    r = |v;
            3'd2:    r = ~&v;
            3'd3:    r = ~|v;
            3'd4:    r = ^v;
            3'd5:    r = ~^v;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  func_q, func_d;
    logic [2:0]  vec_q, vec_d;
    logic [7:0]  hold_q, hold_d;
    logic [2:0]  abc_q, abc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [3:0]  err_cnt_q, err_cnt_d;
    logic [7:0]  fail_vec_q, fail_vec_d;

    logic        func_legal_s;
    logic        sample_s;
    logic        mismatch_s;
    logic        last_vec_s;

    assign func_legal_s = (func < 3'd6);
    assign sample_s     = (state_q == ST_RUN) && (hold_q == HOLD_LAST);
    assign mismatch_s   = sample_s && (f_in != gate_ref(func_q, vec_q));
    assign last_vec_s   = (vec_q == 3'd7);

    // State register and all registered datapath/outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            func_q     <= 3'd0;
            vec_q      <= 3'd0;
            hold_q     <= 8'd0;
            abc_q      <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= 4'd0;
            fail_vec_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            func_q     <= func_d;
            vec_q      <= vec_d;
            hold_q     <= hold_d;
            abc_q      <= abc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    // Next-state logic: start only counts in IDLE, sweep ends after vector 7.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (func_legal_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (sample_s && last_vec_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath logic: vector stepping, result accumulation, status.
    always_comb begin
        func_d     = func_q;
        vec_d      = vec_q;
        hold_d     = hold_q;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        fail_vec_d = fail_vec_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Legal or not, an accepted start wipes the old result.
                    pass_d     = 1'b0;
                    err_cnt_d  = 4'd0;
                    fail_vec_d = 8'd0;
                    vec_d      = 3'd0;
                    hold_d     = 8'd0;
                    if (func_legal_s) begin
                        func_d = func;
                    end else begin
                        func_d = func_q;
                    end
                end else begin
                    hold_d = hold_q;
                end
            end
            ST_RUN: begin
                if (sample_s) begin
                    hold_d = 8'd0;
                    if (mismatch_s) begin
                        fail_vec_d = fail_vec_q | (8'd1 << vec_q);
                        err_cnt_d  = err_cnt_q + 4'd1;
                    end else begin
                        fail_vec_d = fail_vec_q;
                    end
                    if (last_vec_s) begin
                        // Final verdict includes this last sample.
                        pass_d = (err_cnt_q == 4'd0) && !mismatch_s;
                    end else begin
                        vec_d = vec_q + 3'd1;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            ST_DONE: begin
                hold_d = 8'd0;
            end
            default: begin
                hold_d = 8'd0;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
        if (state_d == ST_RUN) begin
            abc_d = vec_d;
        end else begin
            abc_d = 3'd0;
        end
    end

    assign a        = abc_q[2];
    assign b        = abc_q[1];
    assign c        = abc_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_cnt_q;
    assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Randomized self-checking bench for gate_vector_sequencer. A behavioural
// gate model (truth table computed from the count of ones, optionally with
// injected faults) feeds f_in. Expected timing and results are derived from
// the sweep rules with plain arithmetic.
module tb_gate_vector_sequencer;

    localparam int H = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] func;
    logic       a, b, c;
    logic       f_in;
    logic       busy, done, pass;
    logic [3:0] err_cnt;
    logic [7:0] fail_vec;

    int n_checks = 0;
    int n_errors = 0;

    // Gate-model controls: mode 0 = ideal gate of gate_func XOR fault mask,
    // mode 1 = output tied to 0, mode 2 = NOR regardless of gate_func.
    int         gate_mode;
    logic [2:0] gate_func;
    logic [7:0] gate_mask;

    gate_vector_sequencer #(.HOLD_CYCLES(H)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .func     (func),
        .a        (a),
        .b        (b),
        .c        (c),
        .f_in     (f_in),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .fail_vec (fail_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ideal_out(input logic [2:0] fn, input int v);
        int ones;
        ones = (v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1);
        case (fn)
            3'd0:    return ones == 3;
            3'd1:    return ones >= 1;
            3'd2:    return ones != 3;
            3'd3:    return ones == 0;
            3'd4:    return (ones % 2) == 1;
            3'd5:    return (ones % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic model_out(input int mode, input logic [2:0] fn,
                                       input logic [7:0] mask, input int v);
        case (mode)
            0:       return ideal_out(fn, v) ^ mask[v];
            1:       return 1'b0;
            2:       return ideal_out(3'd3, v);
            default: return 1'b0;
        endcase
    endfunction

    always_comb f_in = model_out(gate_mode, gate_func, gate_mask, int'({a, b, c}));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One start, then watch every cycle until a few cycles past done.
    task automatic run_sweep(input string tag, input logic [2:0] fn, input int mode,
                             input logic [7:0] mask, input bit poke);
        logic [7:0] exp_fail;
        int         exp_err;
        int         span;
        int         dones;
        bit         legal;
        legal    = (fn < 3'd6);
        exp_fail = 8'd0;
        exp_err  = 0;
        if (legal) begin
            for (int v = 0; v < 8; v++) begin
                if (model_out(mode, fn, mask, v) != ideal_out(fn, v)) begin
                    exp_fail[v] = 1'b1;
                    exp_err++;
                end
            end
        end
        span      = legal ? 8 * H : 0;
        dones     = 0;
        gate_mode = mode;
        gate_func = fn;
        gate_mask = mask;
        @(negedge clk);
        start = 1'b1;
        func  = fn;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n <= span + 2; n++) begin
            if (n < span) begin
                check_eq({tag, "_run"}, {busy, done, a, b, c}, {1'b1, 1'b0, 3'(n / H)});
            end else if (n == span) begin
                check_eq({tag, "_done"}, {busy, done, a, b, c}, 5'b01000);
            end else begin
                check_eq({tag, "_idle"}, {busy, done, a, b, c}, 5'b00000);
            end
            if (n >= span) begin
                check_eq({tag, "_err"}, err_cnt, exp_err);
                check_eq({tag, "_fail"}, fail_vec, exp_fail);
                check_eq({tag, "_pass"}, pass, (legal && exp_err == 0) ? 1 : 0);
            end
            if (done) dones++;
            start = poke && ((n == 3 && n < span) || n == span);
            func  = poke ? (fn ^ 3'd1) : fn;
            @(negedge clk);
        end
        start = 1'b0;
        func  = fn;
        check_eq({tag, "_ndone"}, dones, 1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        func      = 3'd0;
        gate_mode = 0;
        gate_func = 3'd0;
        gate_mask = 8'd0;
        repeat (2) @(negedge clk);
        check_eq("reset_out", {a, b, c, busy, done, pass}, 6'd0);
        check_eq("reset_err", err_cnt, 0);
        check_eq("reset_fail", fail_vec, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases with spec-stated results.
        run_sweep("nor_ok", 3'd3, 0, 8'h00, 1'b0);
        check_eq("nor_ok_pass", pass, 1);
        run_sweep("nor_tie0", 3'd3, 1, 8'h00, 1'b0);
        check_eq("nor_tie0_fail", fail_vec, 8'h01);
        run_sweep("xor_nor", 3'd4, 2, 8'h00, 1'b0);
        check_eq("xor_nor_fail", fail_vec, 8'h97);
        check_eq("xor_nor_err", err_cnt, 5);

        // start pulses in RUN and DONE are ignored.
        run_sweep("poke", 3'd0, 0, 8'h21, 1'b1);

        // Illegal functions.
        run_sweep("ill6", 3'd6, 0, 8'h00, 1'b0);
        run_sweep("ill7", 3'd7, 0, 8'h00, 1'b0);

        // Randomized functions and fault maps.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] rf;
            logic [7:0] rm;
            rf = 3'($urandom_range(5, 0));
            rm = (i % 3 == 0) ? 8'h00 : 8'($urandom);
            run_sweep("rand", rf, 0, rm, i[0]);
        end

        // Reset in the middle of vector 3, with errors already recorded.
        gate_mode = 0;
        gate_func = 3'd3;
        gate_mask = 8'h05;
        @(negedge clk);
        start = 1'b1;
        func  = 3'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3 * H + 1) @(negedge clk);
        check_eq("mid_vec3", {busy, a, b, c}, 4'b1011);
        check_eq("mid_err", err_cnt, 2);
        rst = 1'b1;
        #1;
        check_eq("rst_out", {a, b, c, busy, done, pass}, 6'd0);
        check_eq("rst_err", err_cnt, 0);
        check_eq("rst_fail", fail_vec, 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int dones = 0;
            int busys = 0;
            for (int n = 0; n < 6 * H; n++) begin
                @(negedge clk);
                if (done) dones++;
                if (busy) busys++;
            end
            check_eq("rst_nodone", dones, 0);
            check_eq("rst_nobusy", busys, 0);
        end
        run_sweep("after_rst", 3'd5, 0, 8'h40, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gate_vector_sequencer.md
# gate_vector_sequencer

Self-checking stimulus source and response checker for 3-input combinational gate blocks. It drives the eight input patterns (a, b, c) in ascending order, holds each for a programmable number of clock cycles and samples the gate output at the end of each hold. It compares every sample against the expected truth-table value for a selected gate function and reports a per-vector fail map, an error count and pass/done status. It sits directly upstream of the gate under test and also consumes the gate's output. It is the synthesizable, clocked replacement for hand-written `#delay` stimulus.

## Interface
- HOLD_CYCLES, 4, cycles each input vector is held before the gate output is sampled; legal range 1..255.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; accepted only in IDLE.
- func  input  3  gate function, latched at start: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR; 6 and 7 are illegal.
- a  output  1  stimulus bit 2 (vector MSB), registered.
- b  output  1  stimulus bit 1, registered.
- c  output  1  stimulus bit 0, registered.
- f_in  input  1  output of the gate under test.
- busy  output  1  high while a sweep is running.
- done  output  1  one-cycle pulse at the end of a sweep.
- pass  output  1  result of the last sweep; held until the next accepted start.
- err_cnt  output  4  number of mismatching vectors in the last sweep, 0..8.
- fail_vec  output  8  bit v set when vector v = {a,b,c} mismatched.

## Operation
- States:
  - IDLE: a=b=c=0, busy=0.
  - RUN: sweep in progress.
  - DONE: lasts one cycle, then returns to IDLE.
- IDLE, start=1, legal func:
  - latch func;
  - clear err_cnt, fail_vec and pass;
  - set vec=0 and hold_cnt=0;
  - go to RUN.
- IDLE, start=1, func 6 or 7:
  - go to DONE;
  - pass=0, err_cnt=0, fail_vec=0;
  - no vectors are driven.
- RUN:
  - {a,b,c}=vec.
  - hold_cnt increments every cycle.
  - When hold_cnt==HOLD_CYCLES-1, sample f_in and compare it with expected(func, vec). On mismatch, set fail_vec[vec] and add 1 to err_cnt. Then reset hold_cnt to 0.
  - If vec==7, go to DONE; otherwise vec+1.
- DONE:
  - done=1 for exactly one cycle;
  - pass=(err_cnt==0) for a legal func;
  - a=b=c=0, busy=0.
- start is ignored in RUN and in DONE; it is not queued.
- err_cnt cannot exceed 8. The 4-bit width is sufficient, so no wrap-around occurs.
- Reset, including reset mid-sweep:
  - the sweep is abandoned; state returns to IDLE;
  - a=b=c=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0;
  - no done pulse is produced.

## Timing
- Let E0 be the clock edge that samples start=1 in IDLE.
  - Vector v is driven on a/b/c from edge E0 + v·HOLD_CYCLES.
  - f_in for vector v is sampled at edge E0 + (v+1)·HOLD_CYCLES − 1, so the gate has HOLD_CYCLES−1 cycles to settle. With HOLD_CYCLES=1, the sample is taken in the same cycle the vector is driven.
- busy rises at E0 and falls at the edge that enters DONE: E0 + 8·HOLD_CYCLES.
- done is high for the cycle after E0 + 8·HOLD_CYCLES. pass, err_cnt and fail_vec are valid in that same cycle and stay stable afterwards.
- Illegal func: done is high for the cycle after E0; busy never rises.
- The earliest next accepted start is the first IDLE cycle after done.
- Total sweep latency: 8·HOLD_CYCLES + 1 cycles from start to done.

## Test plan
- HOLD_CYCLES=4, func=3 (NOR), f_in driven by a correct NOR of a/b/c. Required: done 33 cycles after start; pass=1, err_cnt=0, fail_vec=8'h00; each vector held 4 cycles in order 000..111.
- func=3, f_in tied to 0. Required: err_cnt=1, fail_vec=8'h01, pass=0.
- func=4 (XOR), f_in driven by a NOR model. Required: err_cnt=5, fail_vec=8'h97, pass=0.
- Assert rst for one cycle during vector 3. Required: immediately a=b=c=0, busy=0, err_cnt=0, fail_vec=0, and no done pulse. A new start then completes a full sweep with correct results.
- Pulse start again during RUN, and also during the DONE cycle. Required: both ignored; the sweep timing and result are unchanged and exactly one done pulse is produced.
- func=6 with start. Required: done on the next cycle; busy never high; pass=0, err_cnt=0, fail_vec=0; a/b/c stay 0.
